// File: rtl/multi_square_object.sv
// N-object rectangle hit tester: per-object movable top-left and visible flag,
// double-buffered position updates, registered lowest-index-wins hit report.
module multi_square_object #(
    parameter int N_OBJ           = 4,
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int COORD_W         = 11,
    parameter int INIT_X          = 550,
    parameter int INIT_Y          = 22,
    localparam int IDX_W          = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               startOfFrame,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               wr_visible,
    output logic               drawingRequest,
    output logic [IDX_W-1:0]   objIndex,
    output logic [COORD_W-1:0] offsetX,
    output logic [COORD_W-1:0] offsetY,
    output logic [N_OBJ-1:0]   hitMask
);

    localparam int SUM_W = COORD_W + 1;
    localparam logic [SUM_W-1:0] W_EXT = SUM_W'(OBJECT_WIDTH_X);
    localparam logic [SUM_W-1:0] H_EXT = SUM_W'(OBJECT_HEIGHT_Y);

    logic [COORD_W-1:0] shx_q [N_OBJ];
    logic [COORD_W-1:0] shy_q [N_OBJ];
    logic               shv_q [N_OBJ];
    logic [COORD_W-1:0] acx_q [N_OBJ];
    logic [COORD_W-1:0] acy_q [N_OBJ];
    logic               acv_q [N_OBJ];

    logic [COORD_W-1:0] shx_d [N_OBJ];
    logic [COORD_W-1:0] shy_d [N_OBJ];
    logic               shv_d [N_OBJ];
    logic [COORD_W-1:0] acx_d [N_OBJ];
    logic [COORD_W-1:0] acy_d [N_OBJ];
    logic               acv_d [N_OBJ];

    logic               draw_q, draw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] offx_q, offx_d;
    logic [COORD_W-1:0] offy_q, offy_d;
    logic [N_OBJ-1:0]   mask_q, mask_d;

    // Out-of-range wr_idx matches no entry, so such writes fall away naturally.
    // Commit reads the post-write shadow, which forwards a same-cycle write.
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            shx_d[i] = shx_q[i];
            shy_d[i] = shy_q[i];
            shv_d[i] = shv_q[i];
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                shx_d[i] = wr_x;
                shy_d[i] = wr_y;
                shv_d[i] = wr_visible;
            end
            acx_d[i] = startOfFrame ? shx_d[i] : acx_q[i];
            acy_d[i] = startOfFrame ? shy_d[i] : acy_q[i];
            acv_d[i] = startOfFrame ? shv_d[i] : acv_q[i];
        end
    end

    // Far edges are computed one bit wider so objects near max coordinate clip.
    always_comb begin
        mask_d = '0;
        idx_d  = '0;
        offx_d = '0;
        offy_d = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            mask_d[i] = acv_q[i]
                && (pixelX >= acx_q[i])
                && ({1'b0, pixelX} < ({1'b0, acx_q[i]} + W_EXT))
                && (pixelY >= acy_q[i])
                && ({1'b0, pixelY} < ({1'b0, acy_q[i]} + H_EXT));
        end
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (mask_d[i]) begin
                idx_d  = IDX_W'(i);
                offx_d = pixelX - acx_q[i];
                offy_d = pixelY - acy_q[i];
            end
        end
        draw_d = |mask_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_q <= 1'b0;
            idx_q  <= '0;
            offx_q <= '0;
            offy_q <= '0;
            mask_q <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                shx_q[i] <= COORD_W'(INIT_X);
                shy_q[i] <= COORD_W'(INIT_Y + i * OBJECT_HEIGHT_Y);
                shv_q[i] <= 1'b1;
                acx_q[i] <= COORD_W'(INIT_X);
                acy_q[i] <= COORD_W'(INIT_Y + i * OBJECT_HEIGHT_Y);
                acv_q[i] <= 1'b1;
            end
        end else begin
            draw_q <= draw_d;
            idx_q  <= idx_d;
            offx_q <= offx_d;
            offy_q <= offy_d;
            mask_q <= mask_d;
            for (int i = 0; i < N_OBJ; i++) begin
                shx_q[i] <= shx_d[i];
                shy_q[i] <= shy_d[i];
                shv_q[i] <= shv_d[i];
                acx_q[i] <= acx_d[i];
                acy_q[i] <= acy_d[i];
                acv_q[i] <= acv_d[i];
            end
        end
    end

    assign drawingRequest = draw_q;
    assign objIndex       = idx_q;
    assign offsetX        = offx_q;
    assign offsetY        = offy_q;
    assign hitMask        = mask_q;

endmodule
